// File: rtl/mochila_obi_pkg.sv
// OBI request/response structures shared by the mochila RAM arbiter and its requesters.
package mochila_obi_pkg;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;

endpackage

// File: rtl/mochila_ram_arbiter.sv
// N-to-1 OBI arbiter for the memory_sys RAM port: round-robin selection with request lock,
// plus an ID FIFO routing responses back. Define MOCHILA_ARB_FIXED_PRIO_EN for fixed priority.
module mochila_ram_arbiter
    import mochila_obi_pkg::*;
#(
    parameter int unsigned NUM_MASTERS     = 3,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  obi_req_t  master_req_i  [NUM_MASTERS],
    output obi_resp_t master_resp_o [NUM_MASTERS],
    output obi_req_t  ram_req_o,
    input  obi_resp_t ram_resp_i,
    output logic      err_o
);

    localparam int unsigned IdxW = $clog2(NUM_MASTERS);
    localparam int unsigned PtrW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1);

    localparam logic [PtrW-1:0] LastPtr = PtrW'(MAX_OUTSTANDING - 1);
    localparam logic [CntW-1:0] FullCnt = CntW'(MAX_OUTSTANDING);

    localparam logic [0:0] StIdle   = 1'b0;
    localparam logic [0:0] StLocked = 1'b1;

    logic [0:0]      state_q, state_d;
    logic [IdxW-1:0] lock_idx_q, lock_idx_d;
    logic [IdxW-1:0] fifo_q [MAX_OUTSTANDING];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] count_q;
    logic            err_q;

    logic [IdxW-1:0] sel_idx, head_idx, cand_idx;
    int unsigned     cand;
    logic            any_req, found, fifo_full, fifo_empty;
    logic            req_out, handshake, pop;

`ifndef MOCHILA_ARB_FIXED_PRIO_EN
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_MASTERS - 1);
    logic [IdxW-1:0] rr_ptr_q;
`endif

    assign fifo_full  = (count_q == FullCnt);
    assign fifo_empty = (count_q == '0);
    assign head_idx   = fifo_q[rd_ptr_q];

    // First requester at or above the search start; a pending lock overrides the search.
    always_comb begin
        any_req  = 1'b0;
        found    = 1'b0;
        sel_idx  = '0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
`ifdef MOCHILA_ARB_FIXED_PRIO_EN
            cand = i;
`else
            cand = 32'(rr_ptr_q) + i;
            if (cand >= NUM_MASTERS) begin
                cand = cand - NUM_MASTERS;
            end
`endif
            cand_idx = IdxW'(cand);
            any_req  = any_req | master_req_i[i].req;
            if (!found && master_req_i[cand_idx].req) begin
                found   = 1'b1;
                sel_idx = cand_idx;
            end
        end
        if (state_q == StLocked) begin
            sel_idx = lock_idx_q;
        end
    end

    assign req_out   = rst_ni & (any_req | (state_q == StLocked)) & ~fifo_full;
    assign handshake = req_out & ram_resp_i.gnt;
    assign pop       = rst_ni & ram_resp_i.rvalid & ~fifo_empty;
    assign err_o     = err_q;

    always_comb begin
        ram_req_o = '0;
        if (req_out) begin
            ram_req_o     = master_req_i[sel_idx];
            ram_req_o.req = 1'b1;
        end
        for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
            master_resp_o[k] = '0;
            if (req_out && (sel_idx == IdxW'(k))) begin
                master_resp_o[k].gnt = ram_resp_i.gnt;
            end
            if (pop && (head_idx == IdxW'(k))) begin
                master_resp_o[k].rvalid = 1'b1;
                master_resp_o[k].rdata  = ram_resp_i.rdata;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        lock_idx_d = lock_idx_q;
        case (state_q)
            StIdle: begin
                if (req_out && !ram_resp_i.gnt) begin
                    state_d    = StLocked;
                    lock_idx_d = sel_idx;
                end
            end
            StLocked: begin
                if (handshake) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            lock_idx_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            lock_idx_q <= lock_idx_d;
            if (handshake) begin
                wr_ptr_q <= (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
            end
            if (handshake && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (!handshake && pop) begin
                count_q <= count_q - 1'b1;
            end
            // An orphan response means the RAM and arbiter disagree; latch it until reset.
            if (ram_resp_i.rvalid && fifo_empty) begin
                err_q <= 1'b1;
            end
        end
    end

`ifndef MOCHILA_ARB_FIXED_PRIO_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q <= '0;
        end else if (handshake) begin
            rr_ptr_q <= (sel_idx == LastIdx) ? '0 : sel_idx + 1'b1;
        end
    end
`endif

    // ID storage needs no reset: entries are only read once the occupancy says they are valid.
    always_ff @(posedge clk_i) begin
        if (handshake) begin
            fifo_q[wr_ptr_q] <= sel_idx;
        end
    end

endmodule

// File: tb/tb_mochila_ram_arbiter.sv
// Self-checking bench for mochila_ram_arbiter: scoreboard of expected (master, rdata) responses.
module tb_mochila_ram_arbiter;
    import mochila_obi_pkg::*;

    localparam int NM = 3;

    typedef struct {
        int          m;
        logic [31:0] data;
    } sb_t;

    logic      clk = 1'b0;
    logic      rst_n;
    obi_req_t  mreq  [NM];
    obi_resp_t mresp [NM];
    obi_req_t  ram_req;
    obi_resp_t ram_resp;
    logic      err;

    int          checks = 0;
    int          errors = 0;
    int          ptr_m  = 0;
    sb_t         sb[$];
    logic [31:0] ram_q[$];

    always #5 clk = ~clk;

    mochila_ram_arbiter #(
        .NUM_MASTERS    (NM),
        .MAX_OUTSTANDING(2)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .master_req_i (mreq),
        .master_resp_o(mresp),
        .ram_req_o    (ram_req),
        .ram_resp_i   (ram_resp),
        .err_o        (err)
    );

    function automatic logic [31:0] addr_of(input int m);
        return 32'(m) << 8;
    endfunction

    function automatic logic [31:0] ram_data(input logic [31:0] a);
        return a ^ 32'hD00D_0000;
    endfunction

    function automatic int model_pick(input logic [NM-1:0] mask, input int ptr);
        int start = ptr;
`ifdef MOCHILA_ARB_FIXED_PRIO_EN
        start = 0;
`endif
        for (int i = 0; i < NM; i++) begin
            if (mask[(start + i) % NM]) return (start + i) % NM;
        end
        return -1;
    endfunction

    task automatic set_req(input int m, input logic r);
        mreq[m].req   = r;
        mreq[m].we    = m[0];
        mreq[m].be    = 4'hF;
        mreq[m].addr  = addr_of(m);
        mreq[m].wdata = 32'hA000_0000 | 32'(m);
    endtask

    // RAM side stimulus; response data comes from the model of what the RAM accepted.
    task automatic drive(input logic g, input logic rv);
        ram_resp.gnt    = g;
        ram_resp.rvalid = rv;
        ram_resp.rdata  = 32'h0;
        if (rv && ram_q.size() > 0) ram_resp.rdata = ram_q.pop_front();
        else if (rv) ram_resp.rdata = 32'hDEAD_BEEF;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int m = 0; m < NM; m++) set_req(m, 1'b1);
        ram_resp = '{gnt: 1'b1, rvalid: 1'b1, rdata: 32'hFFFF_FFFF};
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (ram_req !== '0) begin
            errors++; $display("FAIL reset_ram_req got %h exp 0", ram_req);
        end
        for (int k = 0; k < NM; k++) begin
            checks++;
            if (mresp[k] !== '0) begin
                errors++; $display("FAIL reset_resp[%0d] got %h exp 0", k, mresp[k]);
            end
        end
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err); end
        @(negedge clk);
        for (int m = 0; m < NM; m++) set_req(m, 1'b0);
        drive(1'b0, 1'b0);
        rst_n = 1'b1;
        ptr_m = 0;
    endtask

    task automatic test_round_robin();
        int          e;
        logic        rv = 1'b0;
        sb_t         s;
        logic [31:0] exp_a;
        for (int m = 0; m < NM; m++) set_req(m, 1'b1);
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            if (c == 6) for (int m = 0; m < NM; m++) set_req(m, 1'b0);
            drive(c < 6, rv);
            #1;
            if (rv) begin
                s = sb.pop_front();
                for (int k = 0; k < NM; k++) begin
                    checks++;
                    if (mresp[k].rvalid !== (k == s.m) ||
                        mresp[k].rdata !== ((k == s.m) ? s.data : 32'h0)) begin
                        errors++;
                        $display("FAIL rr_resp c=%0d k=%0d got rv=%b rd=%h exp owner %0d rd=%h",
                                 c, k, mresp[k].rvalid, mresp[k].rdata, s.m, s.data);
                    end
                end
            end
            if (c < 6) begin
                e = model_pick(3'b111, ptr_m);
                exp_a = addr_of(e);
                checks++;
                if (ram_req.req !== 1'b1 || ram_req.addr !== exp_a ||
                    ram_req.wdata !== (32'hA000_0000 | 32'(e))) begin
                    errors++;
                    $display("FAIL rr_sel c=%0d got req=%b addr=%h exp addr=%h",
                             c, ram_req.req, ram_req.addr, exp_a);
                end
                for (int k = 0; k < NM; k++) begin
                    checks++;
                    if (mresp[k].gnt !== (k == e)) begin
                        errors++; $display("FAIL rr_gnt c=%0d k=%0d got %b exp %b",
                                           c, k, mresp[k].gnt, (k == e));
                    end
                end
                sb.push_back('{m: e, data: ram_data(exp_a)});
                if (ram_req.req) ram_q.push_back(ram_data(ram_req.addr));
                ptr_m = (e + 1) % NM;
                rv = 1'b1;
            end else begin
                checks++;
                if (ram_req.req !== 1'b0) begin
                    errors++; $display("FAIL rr_idle got %b exp 0", ram_req.req);
                end
                rv = 1'b0;
            end
        end
    endtask

    task automatic test_lock();
        sb_t s;
        set_req(1, 1'b1);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (c == 2) set_req(0, 1'b1);
            drive(c == 3, 1'b0);
            #1;
            checks++;
            if (ram_req.req !== 1'b1 || ram_req.addr !== 32'h100) begin
                errors++; $display("FAIL lock_addr c=%0d got req=%b addr=%h exp addr=00000100",
                                   c, ram_req.req, ram_req.addr);
            end
            checks++;
            if (mresp[1].gnt !== (c == 3) || mresp[0].gnt !== 1'b0) begin
                errors++; $display("FAIL lock_gnt c=%0d got g1=%b g0=%b exp g1=%b g0=0",
                                   c, mresp[1].gnt, mresp[0].gnt, (c == 3));
            end
        end
        sb.push_back('{m: 1, data: ram_data(32'h100)});
        ram_q.push_back(ram_data(ram_req.addr));
        ptr_m = 2;
        // Master 0 is served next once master 1 completes.
        @(negedge clk);
        set_req(1, 1'b0);
        drive(1'b1, 1'b1);
        #1;
        checks++;
        if (ram_req.addr !== addr_of(model_pick(3'b001, ptr_m)) || mresp[0].gnt !== 1'b1) begin
            errors++; $display("FAIL lock_next got addr=%h g0=%b exp addr=%h g0=1",
                               ram_req.addr, mresp[0].gnt, addr_of(0));
        end
        s = sb.pop_front();
        checks++;
        if (mresp[s.m].rvalid !== 1'b1 || mresp[s.m].rdata !== s.data || mresp[0].rvalid !== 1'b0) begin
            errors++; $display("FAIL lock_resp1 got rv=%b rd=%h exp rv=1 rd=%h",
                               mresp[s.m].rvalid, mresp[s.m].rdata, s.data);
        end
        sb.push_back('{m: 0, data: ram_data(addr_of(0))});
        if (ram_req.req) ram_q.push_back(ram_data(ram_req.addr));
        ptr_m = 1;
        @(negedge clk);
        set_req(0, 1'b0);
        drive(1'b0, 1'b1);
        #1;
        s = sb.pop_front();
        checks++;
        if (ram_req.req !== 1'b0 || mresp[s.m].rvalid !== 1'b1 || mresp[s.m].rdata !== s.data) begin
            errors++; $display("FAIL lock_resp0 got req=%b rv=%b rd=%h exp req=0 rv=1 rd=%h",
                               ram_req.req, mresp[s.m].rvalid, mresp[s.m].rdata, s.data);
        end
    endtask

    task automatic test_full();
        logic exp_req [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic rv_in   [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        sb_t  s;
        set_req(2, 1'b1);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c == 6) set_req(2, 1'b0);
            drive(c < 6, rv_in[c]);
            #1;
            checks++;
            if (ram_req.req !== exp_req[c] || mresp[2].gnt !== (exp_req[c] && c < 6)) begin
                errors++; $display("FAIL full_req c=%0d got req=%b g2=%b exp req=%b",
                                   c, ram_req.req, mresp[2].gnt, exp_req[c]);
            end
            if (rv_in[c]) begin
                if (sb.size() == 0) begin
                    checks++; errors++; $display("FAIL full_sb c=%0d got empty exp entry", c);
                end else begin
                    s = sb.pop_front();
                    checks++;
                    if (mresp[s.m].rvalid !== 1'b1 || mresp[s.m].rdata !== s.data) begin
                        errors++; $display("FAIL full_resp c=%0d got rv=%b rd=%h exp rv=1 rd=%h",
                                           c, mresp[s.m].rvalid, mresp[s.m].rdata, s.data);
                    end
                end
            end
            if (exp_req[c] && c < 6) begin
                sb.push_back('{m: model_pick(3'b100, ptr_m), data: ram_data(addr_of(2))});
                ptr_m = 0;
                if (ram_req.req) ram_q.push_back(ram_data(ram_req.addr));
            end
        end
    endtask

    task automatic test_err();
        @(negedge clk);
        drive(1'b0, 1'b1);
        #1;
        for (int k = 0; k < NM; k++) begin
            checks++;
            if (mresp[k].rvalid !== 1'b0) begin
                errors++; $display("FAIL err_drop k=%0d got rv=%b exp 0", k, mresp[k].rvalid);
            end
        end
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL err_early got %b exp 0", err); end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            drive(1'b0, 1'b0);
            #1;
            checks++;
            if (err !== 1'b1) begin errors++; $display("FAIL err_sticky c=%0d got %b exp 1", c, err); end
        end
    endtask

    task automatic test_reset_mid();
        int  e;
        sb_t s;
        set_req(1, 1'b1);
        set_req(2, 1'b1);
        repeat (2) begin
            @(negedge clk);
            drive(1'b1, 1'b0);
            #1;
            e = model_pick(3'b110, ptr_m);
            checks++;
            if (ram_req.addr !== addr_of(e)) begin
                errors++; $display("FAIL rst_pre got addr=%h exp %h", ram_req.addr, addr_of(e));
            end
            ptr_m = (e + 1) % NM;
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (ram_req !== '0 || mresp[1] !== '0 || mresp[2] !== '0 || err !== 1'b0) begin
            errors++; $display("FAIL rst_mid got req=%b g1=%b g2=%b err=%b exp all 0",
                               ram_req.req, mresp[1].gnt, mresp[2].gnt, err);
        end
        sb.delete();
        ram_q.delete();
        ptr_m = 0;
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 1'b0);
        #1;
        e = model_pick(3'b110, ptr_m);
        checks++;
        if (ram_req.addr !== addr_of(e) || mresp[e].gnt !== 1'b1) begin
            errors++; $display("FAIL rst_first got addr=%h exp addr=%h", ram_req.addr, addr_of(e));
        end
        sb.push_back('{m: e, data: ram_data(addr_of(e))});
        if (ram_req.req) ram_q.push_back(ram_data(ram_req.addr));
        @(negedge clk);
        set_req(1, 1'b0);
        set_req(2, 1'b0);
        drive(1'b0, 1'b1);
        #1;
        s = sb.pop_front();
        checks++;
        if (mresp[s.m].rvalid !== 1'b1 || mresp[s.m].rdata !== s.data || err !== 1'b0) begin
            errors++; $display("FAIL rst_resp got rv=%b rd=%h err=%b exp rv=1 rd=%h err=0",
                               mresp[s.m].rvalid, mresp[s.m].rdata, err, s.data);
        end
        // Stale pre-reset responses must be treated as orphans.
        @(negedge clk);
        drive(1'b0, 1'b1);
        #1;
        checks++;
        if (mresp[1].rvalid !== 1'b0 || mresp[2].rvalid !== 1'b0) begin
            errors++; $display("FAIL rst_stale got rv1=%b rv2=%b exp 0",
                               mresp[1].rvalid, mresp[2].rvalid);
        end
        @(negedge clk);
        drive(1'b0, 1'b0);
        #1;
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL rst_err got %b exp 1", err); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int m = 0; m < NM; m++) mreq[m] = '0;
        ram_resp = '0;
        rst_n    = 1'b0;
        test_reset();
        test_round_robin();
        test_lock();
        test_full();
        test_err();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
